// File: rtl/abh_pkg.sv
// Shared definitions for the ABH sequencer: command codes, state encodings
// and the op codes driven onto the ABH datapath.
package abh_pkg;

  typedef enum logic [2:0] {
    CMD_ZP  = 3'd0,
    CMD_STK = 3'd1,
    CMD_ABS = 3'd2,
    CMD_IDX = 3'd3,
    CMD_BR  = 3'd4,
    CMD_PC  = 3'd5,
    CMD_JMP = 3'd6,
    CMD_VEC = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIX  = 2'd1,
    ST_LDPC = 2'd2
  } state_e;

  // op[3:2] selects the base, op[1:0] selects the add term
  localparam logic [3:0] OP_HOLD = 4'b0100;
  localparam logic [3:0] OP_PCH  = 4'b1000;
  localparam logic [3:0] OP_DB   = 4'b1100;
  localparam logic [3:0] OP_ZP   = 4'b0000;
  localparam logic [3:0] OP_STK  = 4'b0001;
  localparam logic [3:0] OP_PC   = 4'b1010;
  localparam logic [3:0] OP_VEC  = 4'b0011;

  function automatic logic [3:0] cmd_op(input cmd_e c);
    logic [3:0] r;
    case (c)
      CMD_ZP:  r = OP_ZP;
      CMD_STK: r = OP_STK;
      CMD_BR:  r = OP_PCH;
      CMD_PC:  r = OP_PC;
      CMD_VEC: r = OP_VEC;
      default: r = OP_DB;
    endcase
    return r;
  endfunction

  // Page-cross fixup: ABH+CI, or ABH-1+CI for a backward branch
  function automatic logic [3:0] fix_op(input logic s);
    return {OP_HOLD[3:1], s} | 4'b0010;
  endfunction

endpackage

// File: rtl/abh_seq_fsm.sv
// State and branch-sign registers of the ABH sequencer plus next-state logic.
// Everything holds while rdy is low.
module abh_seq_fsm
  import abh_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       start,
  input  logic [2:0] cmd,
  input  logic       neg,
  input  logic       ci,
  output logic [1:0] state,
  output logic       s
);

  state_e state_reg;
  logic   s_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      s_reg     <= 1'b0;
    end else if (rdy) begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            case (cmd_e'(cmd))
              CMD_IDX: begin
                if (ci) begin
                  state_reg <= ST_FIX;
                  s_reg     <= 1'b0;
                end
              end
              // A branch crosses a page when the carry disagrees with the sign
              CMD_BR: begin
                if (ci ^ neg) begin
                  state_reg <= ST_FIX;
                  s_reg     <= neg;
                end
              end
              CMD_JMP: state_reg <= ST_LDPC;
              default: state_reg <= ST_IDLE;
            endcase
          end
        end
        // FIX and LDPC last one cycle; unknown encodings recover here too
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign state = state_reg;
  assign s     = s_reg;

endmodule

// File: rtl/abh_seq.sv
// ABH sequencer top: accepts address-high commands and decodes the FSM state
// into op / PCH load / PCH increment controls.
module abh_seq
  import abh_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       start,
  input  logic [2:0] cmd,
  input  logic       neg,
  input  logic       CI,
  output logic [3:0] op,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       ack,
  output logic       busy,
  output logic       penalty
);

  logic [1:0] state;
  logic       s;

  abh_seq_fsm u_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .start (start),
    .cmd   (cmd),
    .neg   (neg),
    .ci    (CI),
    .state (state),
    .s     (s)
  );

  always_comb begin
    op     = OP_HOLD;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    ack    = 1'b0;
    case (state_e'(state))
      ST_IDLE: begin
        if (start) begin
          op  = cmd_op(cmd_e'(cmd));
          ack = 1'b1;
          if (cmd == CMD_PC) begin
            ld_pc  = 1'b1;
            inc_pc = 1'b1;
          end
        end
      end
      ST_FIX:  op = fix_op(s);
      ST_LDPC: ld_pc = 1'b1;
      default: op = OP_HOLD;
    endcase
    // A stalled cycle still shows op but must not commit anything
    if (!rdy) begin
      ack    = 1'b0;
      ld_pc  = 1'b0;
      inc_pc = 1'b0;
    end
  end

  assign busy    = (state == ST_FIX) || (state == ST_LDPC);
  assign penalty = (state == ST_FIX);

endmodule

// File: tb/tb_abh_seq.sv
// Self-checking bench for abh_seq: directed scenarios followed by a long
// random run against a queue-based model of pending follow-on cycles.
module tb_abh_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy;
  logic       start;
  logic [2:0] cmd;
  logic       neg;
  logic       ci;
  logic [3:0] op;
  logic       ld_pc;
  logic       inc_pc;
  logic       ack;
  logic       busy;
  logic       penalty;

  always #5 clk = ~clk;

  abh_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rdy     (rdy),
    .start   (start),
    .cmd     (cmd),
    .neg     (neg),
    .CI      (ci),
    .op      (op),
    .ld_pc   (ld_pc),
    .inc_pc  (inc_pc),
    .ack     (ack),
    .busy    (busy),
    .penalty (penalty)
  );

  int checks   = 0;
  int failures = 0;

  // Each accepted multi-cycle command queues the outputs of its follow-on cycle
  typedef struct packed {
    logic [3:0] op;
    logic       ld;
    logic       pen;
  } fu_t;

  fu_t        fq[$];
  logic [3:0] op_tab [8];
  logic       exp_ack;
  int         model_acks = 0;
  int         dut_acks   = 0;
  int         model_busy = 0;
  int         dut_busy   = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s_i, input logic [2:0] c_i, input logic n_i,
                       input logic ci_i, input logic r_i);
    logic [3:0] e_op;
    logic       e_ld, e_inc, e_ack, e_busy, e_pen;
    @(negedge clk);
    start = s_i;
    cmd   = c_i;
    neg   = n_i;
    ci    = ci_i;
    rdy   = r_i;
    #1;
    if (fq.size() > 0) begin
      e_op   = fq[0].op;
      e_ld   = fq[0].ld & r_i;
      e_inc  = 1'b0;
      e_ack  = 1'b0;
      e_busy = 1'b1;
      e_pen  = fq[0].pen;
    end else begin
      e_op   = s_i ? op_tab[c_i] : 4'b0100;
      e_ack  = s_i & r_i;
      e_ld   = s_i & r_i & (c_i == 3'd5);
      e_inc  = e_ld;
      e_busy = 1'b0;
      e_pen  = 1'b0;
    end
    exp_ack     = e_ack;
    model_acks += 32'(e_ack);
    dut_acks   += 32'(ack === 1'b1);
    model_busy += 32'(e_busy);
    dut_busy   += 32'(busy === 1'b1);
    chk("op", op, e_op);
    chk("ld_pc", {3'b0, ld_pc}, {3'b0, e_ld});
    chk("inc_pc", {3'b0, inc_pc}, {3'b0, e_inc});
    chk("ack", {3'b0, ack}, {3'b0, e_ack});
    chk("busy", {3'b0, busy}, {3'b0, e_busy});
    chk("penalty", {3'b0, penalty}, {3'b0, e_pen});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && rdy) begin
      if (fq.size() > 0) fq.delete(0);
      else if (start) begin
        if (cmd == 3'd3 && ci)
          fq.push_back(fu_t'{op: 4'b0110, ld: 1'b0, pen: 1'b1});
        else if (cmd == 3'd4 && (ci ^ neg))
          fq.push_back(fu_t'{op: {3'b011, neg}, ld: 1'b0, pen: 1'b1});
        else if (cmd == 3'd6)
          fq.push_back(fu_t'{op: 4'b0100, ld: 1'b1, pen: 1'b0});
      end
    end
  endtask

  initial begin
    logic       pend;
    logic [2:0] pcmd;

    op_tab = '{4'b0000, 4'b0001, 4'b1100, 4'b1100, 4'b1000, 4'b1010, 4'b1100, 4'b0011};
    rst_n = 1'b0;
    rdy   = 1'b1;
    start = 1'b0;
    cmd   = 3'd0;
    neg   = 1'b0;
    ci    = 1'b0;
    #1;
    chk("rst_op", op, 4'b0100);
    chk("rst_busy", {3'b0, busy}, 4'b0);
    chk("rst_pen", {3'b0, penalty}, 4'b0);
    chk("rst_ack", {3'b0, ack}, 4'b0);
    chk("rst_ld", {3'b0, ld_pc}, 4'b0);
    chk("rst_inc", {3'b0, inc_pc}, 4'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // first command accepted straight after reset release
    drive(1, 3'd0, 0, 0, 1); chk("zp_op", op, 4'b0000); chk("zp_ack", {3'b0, ack}, 4'b1); tick();

    // indexed page cross and no cross
    drive(1, 3'd3, 0, 1, 1); chk("idx_c0_op", op, 4'b1100); chk("idx_c0_ack", {3'b0, ack}, 4'b1); tick();
    drive(0, 3'd0, 0, 0, 1); chk("idx_fix_op", op, 4'b0110); chk("idx_fix_pen", {3'b0, penalty}, 4'b1);
    chk("idx_fix_busy", {3'b0, busy}, 4'b1); tick();
    drive(0, 3'd0, 0, 0, 1); chk("idx_done", {3'b0, busy}, 4'b0); tick();
    drive(1, 3'd3, 0, 0, 1); tick();
    drive(0, 3'd0, 0, 0, 1); chk("idx_nocross", {3'b0, busy}, 4'b0); tick();

    // branches
    drive(1, 3'd4, 1, 0, 1); chk("br_op", op, 4'b1000); tick();
    drive(0, 3'd0, 0, 0, 1); chk("br_back_fix", op, 4'b0111); tick();
    drive(1, 3'd4, 1, 1, 1); tick();
    drive(0, 3'd0, 0, 0, 1); chk("br_back_nofix", {3'b0, busy}, 4'b0); tick();
    drive(1, 3'd4, 0, 1, 1); tick();
    drive(0, 3'd0, 0, 0, 1); chk("br_fwd_fix", op, 4'b0110); tick();

    // PC and VEC
    drive(1, 3'd5, 0, 0, 1); chk("pc_op", op, 4'b1010); chk("pc_inc", {3'b0, inc_pc}, 4'b1); tick();
    drive(1, 3'd7, 0, 0, 1); chk("vec_op", op, 4'b0011); tick();

    // JMP with a start held through LDPC
    drive(1, 3'd6, 0, 0, 1); chk("jmp_op", op, 4'b1100); tick();
    drive(1, 3'd0, 0, 0, 1); chk("ldpc_op", op, 4'b0100); chk("ldpc_ld", {3'b0, ld_pc}, 4'b1);
    chk("ldpc_inc", {3'b0, inc_pc}, 4'b0); chk("ldpc_ack", {3'b0, ack}, 4'b0); tick();
    drive(1, 3'd0, 0, 0, 1); chk("held_ack", {3'b0, ack}, 4'b1); chk("held_op", op, 4'b0000); tick();

    // stall in FIX
    drive(1, 3'd3, 0, 1, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 3'd0, 0, 0, 0); chk("stall_op", op, 4'b0110); chk("stall_pen", {3'b0, penalty}, 4'b1); tick();
    end
    drive(0, 3'd0, 0, 0, 1); chk("stall_exit_op", op, 4'b0110); tick();
    drive(0, 3'd0, 0, 0, 1); chk("stall_done", {3'b0, busy}, 4'b0); tick();

    // reset in the middle of FIX
    drive(1, 3'd3, 0, 1, 1); tick();
    drive(0, 3'd0, 0, 0, 1); chk("pre_rst_pen", {3'b0, penalty}, 4'b1);
    rst_n = 1'b0;
    #1;
    fq.delete();
    chk("midrst_busy", {3'b0, busy}, 4'b0);
    chk("midrst_op", op, 4'b0100);
    chk("midrst_ld", {3'b0, ld_pc}, 4'b0);
    @(posedge clk);
    #1;
    chk("midrst_hold", {3'b0, busy}, 4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 3'd0, 0, 0, 1); chk("post_rst_ack", {3'b0, ack}, 4'b1); chk("post_rst_op", op, 4'b0000); tick();

    // random run; a requester holds start and cmd until acknowledged
    pend = 1'b0;
    pcmd = 3'd0;
    model_acks = 0; dut_acks = 0; model_busy = 0; dut_busy = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        pcmd = 3'($urandom_range(0, 7));
      end
      drive(pend, pcmd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) != 0);
      tick();
      if (exp_ack) pend = 1'b0;
    end
    chk_int("rand_acks", dut_acks, model_acks);
    chk_int("rand_busy_cycles", dut_busy, model_busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
